// File: rtl/conv_pkg.sv
// Shared constants and types for the conv front end: frame geometry, kernel size,
// sequencer states and raster coordinate types.
package conv_pkg;

  localparam int IMG_W            = 32;
  localparam int IMG_H            = 32;
  localparam int KERNEL           = 5;
  localparam int NUM_CONV_FILTERS = 8;

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [COL_W-1:0] col_t;

  typedef struct packed {
    row_t row;
    col_t col;
  } coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

endpackage

// File: rtl/conv_coord_counter.sv
// Raster row/column counter: one step per inc, column wraps into row, row wraps to 0.
// Registered outputs; clr and rst both return to (0,0) on the next edge.
module conv_coord_counter #(
  parameter int IMG_W = conv_pkg::IMG_W,
  parameter int IMG_H = conv_pkg::IMG_H
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [$clog2(IMG_H)-1:0] row,
  output logic [$clog2(IMG_W)-1:0] col,
  output logic                     at_last
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);

  logic row_end;
  logic col_end;

  assign row_end = (row == ROW_MAX);
  assign col_end = (col == COL_MAX);
  assign at_last = row_end & col_end;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame controller between the feature FWFT and the conv engine: pops only while conv is
// ready, flags full-window pixels, flushes DRAIN_CYCLES after the last pixel, then pulses o_done.
module conv_frame_sequencer #(
  parameter int IMG_W        = conv_pkg::IMG_W,
  parameter int IMG_H        = conv_pkg::IMG_H,
  parameter int KERNEL       = conv_pkg::KERNEL,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_feature_valid,
  input  logic                     i_conv_ready,
  output logic                     o_rd_en,
  output logic                     o_feature_valid,
  output logic                     o_window_valid,
  output logic                     o_last_feature,
  output logic [$clog2(IMG_H)-1:0] o_row,
  output logic [$clog2(IMG_W)-1:0] o_col,
  output logic [$clog2((IMG_W-KERNEL+1)*(IMG_H-KERNEL+1)+1)-1:0] o_window_count,
  output logic                     o_busy,
  output logic                     o_done
);

  import conv_pkg::*;

  localparam int RW  = $clog2(IMG_H);
  localparam int CW  = $clog2(IMG_W);
  localparam int WCW = $clog2((IMG_W-KERNEL+1)*(IMG_H-KERNEL+1)+1);
  localparam int DW  = $clog2(DRAIN_CYCLES + 1);

  localparam logic [RW-1:0] WIN_ROW    = RW'(KERNEL - 1);
  localparam logic [CW-1:0] WIN_COL    = CW'(KERNEL - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  seq_state_t     state_q;
  logic [DW-1:0]  drain_q;
  logic [WCW-1:0] win_cnt_q;
  logic           done_q;

  logic start_ok;
  logic xfer;
  logic win;
  logic at_last;

  // A start coincident with o_done belongs to the frame that just ended and is dropped.
  assign start_ok = (state_q == IDLE) & i_start & ~done_q;

  assign o_rd_en         = (state_q == RUN) & i_conv_ready;
  assign xfer            = o_rd_en & i_feature_valid;
  assign win             = xfer & (o_row >= WIN_ROW) & (o_col >= WIN_COL);
  assign o_feature_valid = xfer;
  assign o_window_valid  = win;
  assign o_last_feature  = xfer & at_last;
  assign o_window_count  = win_cnt_q;
  assign o_busy          = (state_q != IDLE);
  assign o_done          = done_q;

  conv_coord_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_coord (
    .clk     (i_clk),
    .rst     (i_rst),
    .clr     (start_ok),
    .inc     (xfer),
    .row     (o_row),
    .col     (o_col),
    .at_last (at_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      drain_q   <= '0;
      win_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q   <= RUN;
            win_cnt_q <= '0;
          end
        end
        RUN: begin
          if (win) begin
            win_cnt_q <= win_cnt_q + 1'b1;
          end
          if (xfer && at_last) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer: 32x32 frames, kernel 5, 8 drain cycles.
module tb_conv_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       fv;
  logic       cr;
  logic       rd_en;
  logic       feat_vld;
  logic       win_vld;
  logic       last_feat;
  logic [4:0] row;
  logic [4:0] col;
  logic [9:0] wcnt;
  logic       busy;
  logic       done;

  always #10 clk = ~clk;

  conv_frame_sequencer dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_feature_valid (fv),
    .i_conv_ready    (cr),
    .o_rd_en         (rd_en),
    .o_feature_valid (feat_vld),
    .o_window_valid  (win_vld),
    .o_last_feature  (last_feat),
    .o_row           (row),
    .o_col           (col),
    .o_window_count  (wcnt),
    .o_busy          (busy),
    .o_done          (done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // expected-behaviour model: state 0 idle, 1 run, 2 drain
  int m_state = 0, m_row = 0, m_col = 0, m_wcnt = 0, m_dcnt = 0, m_done = 0;
  bit chk_en = 0;
  int cyc = 0;

  // per-frame observations
  int n_xfer, n_win, first_win, last_idx, last_cyc, done_cyc, done_cnt, done_wcnt;
  int w43, w44, gap_hold, xfer_lo;
  logic [31:0] obs_busy, obs_row, obs_col, obs_wcnt, obs_rd;

  task automatic step(input logic s, input logic v, input logic c, input logic r);
    logic e_rd, e_x, e_win, e_last;
    int nd;
    @(negedge clk);
    start = s; fv = v; cr = c; rst = r;
    #1;
    e_rd   = (m_state == 1) && c;
    e_x    = e_rd && v;
    e_win  = e_x && (m_row >= 4) && (m_col >= 4);
    e_last = e_x && (m_row == 31) && (m_col == 31);
    obs_busy = 32'(busy); obs_row = 32'(row); obs_col = 32'(col);
    obs_wcnt = 32'(wcnt); obs_rd = 32'(rd_en);
    if (chk_en) begin
      chk("rd_en",     32'(rd_en),     32'(e_rd));
      chk("feat_vld",  32'(feat_vld),  32'(e_x));
      chk("win_vld",   32'(win_vld),   32'(e_win));
      chk("last_feat", 32'(last_feat), 32'(e_last));
      chk("row",       32'(row),       32'(m_row));
      chk("col",       32'(col),       32'(m_col));
      chk("wcnt",      32'(wcnt),      32'(m_wcnt));
      chk("busy",      32'(busy),      32'(m_state != 0));
      chk("done",      32'(done),      32'(m_done));
      if (feat_vld === 1'b1) begin
        if (win_vld === 1'b1 && first_win < 0) first_win = n_xfer;
        if (last_feat === 1'b1) begin
          last_idx = n_xfer;
          last_cyc = cyc;
        end
        if (row == 5'd4 && col == 5'd3) w43 = int'(win_vld);
        if (row == 5'd4 && col == 5'd4) w44 = int'(win_vld);
        if (!c) xfer_lo++;
        n_xfer++;
      end
      if (win_vld === 1'b1) n_win++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc  = cyc;
        done_wcnt = int'(wcnt);
      end
      if (!v && m_state == 1 && row == 5'd4 && col == 5'd3) gap_hold++;
    end
    if (r) begin
      m_state = 0; m_row = 0; m_col = 0; m_wcnt = 0; m_dcnt = 0; m_done = 0;
    end else begin
      nd = 0;
      case (m_state)
        0: if (s && m_done == 0) begin
             m_state = 1; m_wcnt = 0; m_row = 0; m_col = 0;
           end
        1: if (e_x) begin
             if (e_win) m_wcnt++;
             if (e_last) begin
               m_state = 2; m_dcnt = 0;
             end
             if (m_col == 31) begin
               m_col = 0;
               m_row = (m_row == 31) ? 0 : m_row + 1;
             end else begin
               m_col++;
             end
           end
        default: begin
          m_dcnt++;
          if (m_dcnt == 8) begin
            m_state = 0; nd = 1;
          end
        end
      endcase
      m_done = nd;
    end
    cyc++;
  endtask

  // mode 0 plain, 1 ready toggling, 2 FWFT gap, 3 stray starts, 4 mid-frame reset
  task automatic frame(input int mode);
    logic s, v, c, r;
    bit   row7_done, aborted;
    int   gap_left;
    n_xfer = 0; n_win = 0; first_win = -1; last_idx = -1; last_cyc = 0;
    done_cyc = 0; done_cnt = 0; done_wcnt = -1; w43 = -1; w44 = -1;
    gap_hold = 0; xfer_lo = 0;
    row7_done = 0; aborted = 0; gap_left = 3;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5000 && done_cnt == 0 && !aborted; k++) begin
      s = 1'b0; v = 1'b1; c = 1'b1; r = 1'b0;
      if (mode == 1) c = (k % 4 == 0) || (k % 4 == 3);
      if (mode == 2 && m_state == 1 && m_row == 4 && m_col == 3 && gap_left > 0) begin
        v = 1'b0;
        gap_left--;
      end
      if (mode == 3) begin
        if (m_state == 1 && m_row == 7 && !row7_done) begin
          s = 1'b1;
          row7_done = 1;
        end
        if (m_done != 0) s = 1'b1;
      end
      if (mode == 4 && m_state == 1 && m_row == 10 && m_col == 5) r = 1'b1;
      step(s, v, c, r);
      if (k == 0) chk("wcnt_clr_on_start", obs_wcnt, 0);
      if (r) aborted = 1;
    end
    if (mode == 4) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("rst_busy", obs_busy, 0);
      chk("rst_row",  obs_row,  0);
      chk("rst_col",  obs_col,  0);
      chk("rst_wcnt", obs_wcnt, 0);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("rst_no_done", done_cnt, 0);
    end else begin
      chk("done_cnt",     done_cnt,            1);
      chk("xfers",        n_xfer,              1024);
      chk("first_win",    first_win,           132);
      chk("win_pulses",   n_win,               784);
      chk("wcnt_at_done", done_wcnt,           784);
      chk("last_idx",     last_idx,            1023);
      chk("done_latency", done_cyc - last_cyc, 9);
      if (mode == 1) chk("xfer_ready_low", xfer_lo, 0);
      if (mode == 2) begin
        chk("gap_hold_col3", gap_hold, 3);
        chk("gap_win_c3",    w43,      0);
        chk("gap_win_c4",    w44,      1);
      end
      if (mode == 3) begin
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("start_on_done_busy", obs_busy, 0);
        chk("start_on_done_wcnt", obs_wcnt, 784);
      end
    end
  endtask

  initial begin
    start = 1'b0; fv = 1'b0; cr = 1'b0; rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    chk_en = 1;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("reset_busy",  obs_busy, 0);
    chk("reset_row",   obs_row,  0);
    chk("reset_col",   obs_col,  0);
    chk("reset_wcnt",  obs_wcnt, 0);
    chk("reset_rd_en", obs_rd,   0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    frame(0);
    frame(0);
    frame(1);
    frame(2);
    frame(3);
    frame(4);
    frame(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
